// File: rtl/sprite_compositor.sv
// Sprite compositor: draws palette-indexed sprites over a background,
// with per-frame double-buffered attributes and player collision flags.
//
// Ports:
//   Clk, Reset_n            pixel clock, async active-low reset
//   frame_start             1-cycle pulse, shadow attrs -> active, latch collisions
//   DrawX, DrawY            current pixel coordinate
//   attr_we/idx/x/y/en      shadow attribute write
//   spr_row, spr_col        registered per-sprite ROM address (flat, sprite 0 in LSBs)
//   spr_pix                 per-sprite ROM data, sampled one cycle after address
//   pal_we/addr/data        palette write (read-first)
//   coll_status             previous frame's sprite-0 collisions, bit 0 always 0
//   Red, Green, Blue        registered pixel colour, 3 cycles after DrawX/DrawY
//
// Optional feature: define GRADIENT_BG_EN for a vertical gradient background.
module sprite_compositor #(
    parameter int          NUM_SPRITES = 8,
    parameter int          SPR_W       = 40,
    parameter int          SPR_H       = 40,
    parameter int          PIX_W       = 4,
    parameter int          COORD_W     = 10,
    parameter logic [23:0] BG_COLOR    = 24'h8A8AFF
) (
    input  logic                                 Clk,
    input  logic                                 Reset_n,
    input  logic                                 frame_start,
    input  logic [COORD_W-1:0]                   DrawX,
    input  logic [COORD_W-1:0]                   DrawY,
    input  logic                                 attr_we,
    input  logic [$clog2(NUM_SPRITES)-1:0]       attr_idx,
    input  logic [COORD_W-1:0]                   attr_x,
    input  logic [COORD_W-1:0]                   attr_y,
    input  logic                                 attr_en,
    output logic [NUM_SPRITES*$clog2(SPR_H)-1:0] spr_row,
    output logic [NUM_SPRITES*$clog2(SPR_W)-1:0] spr_col,
    input  logic [NUM_SPRITES*PIX_W-1:0]         spr_pix,
    input  logic                                 pal_we,
    input  logic [PIX_W-1:0]                     pal_addr,
    input  logic [23:0]                          pal_data,
    output logic [NUM_SPRITES-1:0]               coll_status,
    output logic [7:0]                           Red,
    output logic [7:0]                           Green,
    output logic [7:0]                           Blue
);

    localparam int ROW_W = $clog2(SPR_H);
    localparam int COL_W = $clog2(SPR_W);
    localparam int CW1   = COORD_W + 1;
    localparam int PAL_N = 2 ** PIX_W;

    // Attribute storage: shadow written by software, active used for drawing
    logic [COORD_W-1:0]     r_sh_x [NUM_SPRITES];
    logic [COORD_W-1:0]     r_sh_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] r_sh_en;
    logic [COORD_W-1:0]     r_ac_x [NUM_SPRITES];
    logic [COORD_W-1:0]     r_ac_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] r_ac_en;

    logic [23:0]            r_pal [PAL_N];

    logic [NUM_SPRITES-1:0] r_hit;
    logic [23:0]            r_bg1;
    logic [23:0]            r_bg2;
    logic                   r_s2_hit;
    logic [PIX_W-1:0]       r_s2_idx;
    logic [NUM_SPRITES-1:0] r_acc;

    logic [NUM_SPRITES-1:0]       w_hit;
    logic [NUM_SPRITES*ROW_W-1:0] w_row;
    logic [NUM_SPRITES*COL_W-1:0] w_col;
    logic [23:0]                  w_bg;
    logic [NUM_SPRITES-1:0]       w_opq;
    logic [NUM_SPRITES-1:0]       w_coll;
    logic                         w_win;
    logic [PIX_W-1:0]             w_idx;
    logic                         w_attr_ok;

    assign w_attr_ok = attr_we && (int'(attr_idx) < NUM_SPRITES);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_sh_x[i] <= '0;
                r_sh_y[i] <= '0;
                r_ac_x[i] <= '0;
                r_ac_y[i] <= '0;
            end
            r_sh_en <= '0;
            r_ac_en <= '0;
        end else begin
            // Active takes the pre-write shadow when both strobes coincide
            if (frame_start) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    r_ac_x[i] <= r_sh_x[i];
                    r_ac_y[i] <= r_sh_y[i];
                end
                r_ac_en <= r_sh_en;
            end
            if (w_attr_ok) begin
                r_sh_x[attr_idx]  <= attr_x;
                r_sh_y[attr_idx]  <= attr_y;
                r_sh_en[attr_idx] <= attr_en;
            end
        end
    end

`ifdef GRADIENT_BG_EN
    logic [8:0] w_dy;
    logic [7:0] w_rg;
    logic [7:0] w_b;
    assign w_dy = DrawY[9:1];
    assign w_rg = (w_dy >= 9'h08A) ? 8'h00 : (8'h8A - w_dy[7:0]);
    assign w_b  = (w_dy >= 9'h0FF) ? 8'h00 : (8'hFF - w_dy[7:0]);
    assign w_bg = {w_rg, w_rg, w_b};
`else
    assign w_bg = BG_COLOR;
`endif

    // S1: box test at COORD_W+1 bits so a sprite near the right edge never wraps
    always_comb begin
        logic [CW1-1:0] v_px;
        logic [CW1-1:0] v_py;
        logic [CW1-1:0] v_x0;
        logic [CW1-1:0] v_y0;
        logic [CW1-1:0] v_x1;
        logic [CW1-1:0] v_y1;
        w_hit = '0;
        w_row = '0;
        w_col = '0;
        v_px  = {1'b0, DrawX};
        v_py  = {1'b0, DrawY};
        v_x0  = '0;
        v_y0  = '0;
        v_x1  = '0;
        v_y1  = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            v_x0 = {1'b0, r_ac_x[i]};
            v_y0 = {1'b0, r_ac_y[i]};
            v_x1 = v_x0 + CW1'(SPR_W - 1);
            v_y1 = v_y0 + CW1'(SPR_H - 1);
            if (r_ac_en[i] && v_px >= v_x0 && v_px <= v_x1 &&
                v_py >= v_y0 && v_py <= v_y1) begin
                w_hit[i] = 1'b1;
                w_row[i*ROW_W +: ROW_W] = ROW_W'(DrawY - r_ac_y[i]);
                w_col[i*COL_W +: COL_W] = COL_W'(DrawX - r_ac_x[i]);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hit   <= '0;
            spr_row <= '0;
            spr_col <= '0;
            r_bg1   <= '0;
        end else begin
            r_hit   <= w_hit;
            spr_row <= w_row;
            spr_col <= w_col;
            r_bg1   <= w_bg;
        end
    end

    // S2: lowest opaque index wins; collisions only count against sprite 0
    always_comb begin
        w_opq = '0;
        w_win = 1'b0;
        w_idx = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_opq[i] = r_hit[i] && (spr_pix[i*PIX_W +: PIX_W] != '0);
        end
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_opq[i]) begin
                w_win = 1'b1;
                w_idx = spr_pix[i*PIX_W +: PIX_W];
            end
        end
        w_coll    = w_opq[0] ? w_opq : '0;
        w_coll[0] = 1'b0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s2_hit <= 1'b0;
            r_s2_idx <= '0;
            r_bg2    <= '0;
        end else begin
            r_s2_hit <= w_win;
            r_s2_idx <= w_idx;
            r_bg2    <= r_bg1;
        end
    end

    // Collisions still in S2 at frame_start belong to the closing frame
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_acc       <= '0;
            coll_status <= '0;
        end else if (frame_start) begin
            coll_status <= r_acc | w_coll;
            r_acc       <= '0;
        end else begin
            r_acc <= r_acc | w_coll;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < PAL_N; i++) begin
                r_pal[i] <= '0;
            end
        end else if (pal_we) begin
            r_pal[pal_addr] <= pal_data;
        end
    end

    // S3: palette read sees the entry from before a same-cycle write
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Red   <= '0;
            Green <= '0;
            Blue  <= '0;
        end else if (r_s2_hit) begin
            {Red, Green, Blue} <= r_pal[r_s2_idx];
        end else begin
            {Red, Green, Blue} <= r_bg2;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Testbench for sprite_compositor: directed table, multi-cycle sequences,
// and randomized pixels checked against a behavioural scene model.
module tb_sprite_compositor;

    localparam int NS = 8;
    localparam int SW = 40;
    localparam int SH = 40;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        frame_start = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        attr_we = 1'b0;
    logic [2:0]  attr_idx = '0;
    logic [9:0]  attr_x = '0;
    logic [9:0]  attr_y = '0;
    logic        attr_en = 1'b0;
    logic [47:0] spr_row;
    logic [47:0] spr_col;
    logic [31:0] spr_pix;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_addr = '0;
    logic [23:0] pal_data = '0;
    logic [7:0]  coll_status;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;

    sprite_compositor dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY),
        .attr_we(attr_we), .attr_idx(attr_idx), .attr_x(attr_x),
        .attr_y(attr_y), .attr_en(attr_en),
        .spr_row(spr_row), .spr_col(spr_col), .spr_pix(spr_pix),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .coll_status(coll_status),
        .Red(Red), .Green(Green), .Blue(Blue)
    );

    always #5 Clk = ~Clk;

    // Sprite ROMs, answering combinationally from the registered address
    logic [3:0] rom [NS][SH][SW];

    always_comb begin
        spr_pix = '0;
        for (int i = 0; i < NS; i++) begin
            if (spr_row[i*6 +: 6] < 6'd40 && spr_col[i*6 +: 6] < 6'd40)
                spr_pix[i*4 +: 4] = rom[i][int'(spr_row[i*6 +: 6])][int'(spr_col[i*6 +: 6])];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    // Scene model
    logic [23:0] m_pal [16];
    int          m_sx [NS];
    int          m_sy [NS];
    bit          m_sen [NS];
    int          m_ax [NS];
    int          m_ay [NS];
    bit          m_aen [NS];
    logic [7:0]  m_acc;
    logic [7:0]  m_coll;
    logic [23:0] exp_q [$];

    typedef struct {
        int          x;
        int          y;
        bit          use_bg;
        logic [23:0] rgb;
    } vec_t;
    vec_t tab [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] bg_of(input int y);
`ifdef GRADIENT_BG_EN
        int h;
        int rg;
        int b;
        h  = y / 2;
        rg = 138 - h;
        b  = 255 - h;
        if (rg < 0) rg = 0;
        if (b < 0) b = 0;
        return {rg[7:0], rg[7:0], b[7:0]};
`else
        return 24'h8A8AFF + 24'(y * 0);
`endif
    endfunction

    // Colour of a pixel from the scene: first opaque sprite in priority order
    task automatic model_pix(input int x, input int y, output logic [23:0] rgb);
        int dx;
        int dy;
        int win;
        bit op0;
        logic [3:0] p;
        logic [3:0] wp;
        win = -1;
        op0 = 0;
        wp  = '0;
        rgb = bg_of(y);
        for (int s = 0; s < NS; s++) begin
            dx = x - m_ax[s];
            dy = y - m_ay[s];
            if (m_aen[s] && dx >= 0 && dx < SW && dy >= 0 && dy < SH) begin
                p = rom[s][dy][dx];
                if (p != 0) begin
                    if (win < 0) begin
                        win = s;
                        wp  = p;
                    end
                    if (s == 0) op0 = 1;
                    else if (op0) m_acc[s] = 1'b1;
                end
            end
        end
        if (win >= 0) rgb = m_pal[wp];
    endtask

    task automatic tick();
        logic [23:0] e;
        @(posedge Clk);
        #1;
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            chk("rgb", {8'h00, Red, Green, Blue}, {8'h00, e});
        end
    endtask

    task automatic send_pix(input int x, input int y);
        logic [23:0] e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        model_pix(x, y, e);
        exp_q.push_back(e);
        tick();
    endtask

    task automatic send_exp(input int x, input int y, input logic [23:0] e);
        logic [23:0] d;
        DrawX = 10'(x);
        DrawY = 10'(y);
        model_pix(x, y, d);
        exp_q.push_back(e);
        tick();
    endtask

    task automatic idle();
        send_pix(1023, 1023);
    endtask

    task automatic flush();
        repeat (3) idle();
    endtask

    task automatic apply_frame();
        for (int s = 0; s < NS; s++) begin
            m_ax[s]  = m_sx[s];
            m_ay[s]  = m_sy[s];
            m_aen[s] = m_sen[s];
        end
        m_coll = m_acc;
        m_acc  = '0;
    endtask

    task automatic attr_write(input int idx, input int x, input int y, input bit en);
        attr_we  = 1'b1;
        attr_idx = 3'(idx);
        attr_x   = 10'(x);
        attr_y   = 10'(y);
        attr_en  = en;
        idle();
        attr_we  = 1'b0;
        m_sx[idx]  = x;
        m_sy[idx]  = y;
        m_sen[idx] = en;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        idle();
        frame_start = 1'b0;
        apply_frame();
        chk("coll_status", {24'h0, coll_status}, {24'h0, m_coll});
    endtask

    task automatic frame_write(input int idx, input int x, input int y, input bit en);
        frame_start = 1'b1;
        attr_we  = 1'b1;
        attr_idx = 3'(idx);
        attr_x   = 10'(x);
        attr_y   = 10'(y);
        attr_en  = en;
        idle();
        frame_start = 1'b0;
        attr_we     = 1'b0;
        apply_frame();
        m_sx[idx]  = x;
        m_sy[idx]  = y;
        m_sen[idx] = en;
        chk("coll_status", {24'h0, coll_status}, {24'h0, m_coll});
    endtask

    task automatic pal_write(input int a, input logic [23:0] d);
        flush();
        pal_we   = 1'b1;
        pal_addr = 4'(a);
        pal_data = d;
        idle();
        pal_we   = 1'b0;
        m_pal[a] = d;
    endtask

    task automatic fill_rom(input int s, input logic [3:0] v);
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++)
                rom[s][r][c] = v;
    endtask

    task automatic do_reset();
        frame_start = 1'b0;
        attr_we     = 1'b0;
        pal_we      = 1'b0;
        Reset_n     = 1'b0;
        #2;
        chk("reset_rgb", {8'h00, Red, Green, Blue}, 32'h0);
        chk("reset_coll", {24'h0, coll_status}, 32'h0);
        chk("reset_row", {16'h0, spr_row[15:0]} | {16'h0, spr_row[47:32]} | spr_row[31:0], 32'h0);
        chk("reset_col", {16'h0, spr_col[15:0]} | {16'h0, spr_col[47:32]} | spr_col[31:0], 32'h0);
        for (int i = 0; i < 16; i++) m_pal[i] = '0;
        for (int s = 0; s < NS; s++) begin
            m_sx[s] = 0; m_sy[s] = 0; m_sen[s] = 0;
            m_ax[s] = 0; m_ay[s] = 0; m_aen[s] = 0;
        end
        m_acc  = '0;
        m_coll = '0;
        exp_q.delete();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int y0;
        int s;
        int px;
        int py;

        tab[0]  = '{100, 50, 0, 24'hFFFF00};
        tab[1]  = '{140, 50, 1, 24'h0};
        tab[2]  = '{99, 50, 1, 24'h0};
        tab[3]  = '{101, 50, 1, 24'h0};
        tab[4]  = '{305, 200, 0, 24'h0000FF};
        tab[5]  = '{320, 210, 0, 24'h0000FF};
        tab[6]  = '{315, 200, 0, 24'hFFFFFF};
        tab[7]  = '{345, 200, 0, 24'hFFFFFF};
        tab[8]  = '{350, 200, 1, 24'h0};
        tab[9]  = '{320, 240, 1, 24'h0};
        tab[10] = '{339, 239, 0, 24'h0000FF};
        tab[11] = '{0, 0, 1, 24'h0};

        for (int i = 0; i < NS; i++) fill_rom(i, 4'h0);
        #1;
        do_reset();

        // Background everywhere before any frame_start
        for (int x = 0; x < 64; x++) send_pix(x * 7, 100);
        flush();
        chk("idle_coll", {24'h0, coll_status}, 32'h0);
        chk("idle_row", spr_row[31:0], 32'h0);
        chk("idle_col", spr_col[31:0], 32'h0);

        // Directed scene
        fill_rom(0, 4'h1);
        rom[0][0][15] = 4'h0;
        fill_rom(1, 4'h2);
        rom[2][0][0] = 4'h3;
        pal_write(1, 24'h0000FF);
        pal_write(2, 24'hFFFFFF);
        pal_write(3, 24'hFFFF00);
        attr_write(2, 100, 50, 1);
        attr_write(0, 300, 200, 1);
        attr_write(1, 310, 200, 1);
        frame();

        for (int i = 0; i < 12; i++)
            send_exp(tab[i].x, tab[i].y, tab[i].use_bg ? bg_of(tab[i].y) : tab[i].rgb);
        flush();
        frame();
        chk("coll_overlap", {24'h0, coll_status}, 32'h2);

        send_pix(305, 200);
        send_pix(345, 200);
        flush();
        frame();
        chk("coll_clear", {24'h0, coll_status}, 32'h0);

        send_exp(315, 200, 24'hFFFFFF);
        flush();
        frame();
        chk("coll_transp", {24'h0, coll_status}, 32'h0);

        // Palette write landing on the same edge as the read
        send_exp(100, 50, 24'hFFFF00);
        idle();
        pal_we = 1'b1;
        pal_addr = 4'd3;
        pal_data = 24'h00FF00;
        idle();
        pal_we = 1'b0;
        m_pal[3] = 24'h00FF00;
        send_exp(100, 50, 24'h00FF00);
        flush();

        // Attribute write coinciding with frame_start
        fill_rom(3, 4'h4);
        pal_write(4, 24'h123456);
        attr_write(3, 500, 300, 1);
        frame();
        send_exp(505, 300, 24'h123456);
        send_exp(205, 300, bg_of(300));
        frame_write(3, 200, 300, 1);
        send_exp(505, 300, 24'h123456);
        send_exp(205, 300, bg_of(300));
        frame();
        send_exp(205, 300, 24'h123456);
        send_exp(505, 300, bg_of(300));
        flush();

        // Right-edge sprite must not wrap to small x
        fill_rom(4, 4'h5);
        pal_write(5, 24'hABCDEF);
        attr_write(4, 1020, 600, 1);
        frame();
        send_exp(5, 600, bg_of(600));
        send_exp(19, 600, bg_of(600));
        send_exp(0, 600, bg_of(600));
        send_exp(1020, 600, 24'hABCDEF);
        send_exp(1023, 610, 24'hABCDEF);
        chk("addr_row", {26'h0, spr_row[24 +: 6]}, 32'd10);
        chk("addr_col", {26'h0, spr_col[24 +: 6]}, 32'd3);
        send_exp(1019, 600, bg_of(600));
        flush();

        // Reset in the middle of a frame
        send_pix(1020, 600);
        do_reset();
        send_exp(1020, 600, bg_of(600));
        send_exp(1021, 601, bg_of(601));
        flush();
        frame();
        send_exp(1020, 600, bg_of(600));
        flush();

        // Randomized scenes
        for (int round = 0; round < 6; round++) begin
            flush();
            for (int i = 0; i < NS; i++)
                for (int r = 0; r < SH; r++)
                    for (int c = 0; c < SW; c++)
                        rom[i][r][c] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            for (int a = 1; a < 16; a++) pal_write(a, 24'($urandom));
            x0 = int'($urandom_range(100, 800));
            y0 = int'($urandom_range(50, 400));
            attr_write(0, x0, y0, 1);
            for (int i = 1; i < NS; i++)
                attr_write(i, x0 + int'($urandom_range(0, 100)) - 50,
                           y0 + int'($urandom_range(0, 100)) - 50,
                           $urandom_range(0, 4) != 0);
            frame();
            for (int n = 0; n < 400; n++) begin
                s  = int'($urandom_range(0, NS - 1));
                px = m_ax[s] + int'($urandom_range(0, SW + 9)) - 5;
                py = m_ay[s] + int'($urandom_range(0, SH + 9)) - 5;
                if (px < 0) px = 0;
                if (py < 0) py = 0;
                send_pix(px, py);
                if ($urandom_range(0, 63) == 0)
                    attr_write(int'($urandom_range(1, NS - 1)), int'($urandom_range(0, 900)),
                               int'($urandom_range(0, 450)), 1);
            end
            flush();
            frame();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
